// File: rtl/gray_track_3bit.sv
// gray_track_3bit: decodes a 3-bit Gray position word and tracks single-code moves.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   G        - Gray-coded position word, sampled when g_valid is high
//   g_valid  - qualifies G on a clock edge
//   clr      - synchronous clear of tracking state, pos and err_cnt
//   B        - registered binary decode of the last sampled G
//   step     - one-cycle pulse on a legal +/-1 move
//   dir      - direction of the last legal move (1 = up)
//   err      - one-cycle pulse on an illegal multi-code jump
//   err_cnt  - saturating count of illegal jumps
//   pos      - accumulated position, wraps modulo 2^POS_W
module gray_track_3bit #(
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       G,
    input  logic             g_valid,
    input  logic             clr,
    output logic [2:0]       B,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [3:0]       err_cnt,
    output logic [POS_W-1:0] pos
);
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t           state, state_nx;
    logic [2:0]       ref_code, ref_nx, b, b_nx;
    logic             step_nx, dir_nx, err_nx, up, down;
    logic [3:0]       cnt_nx;
    logic [POS_W-1:0] pos_nx;

    // Each binary bit is the XOR of all Gray bits at or above it.
    assign b    = {G[2], G[2] ^ G[1], G[2] ^ G[1] ^ G[0]};
    // 3-bit arithmetic makes 7->0 an up move and 0->7 a down move.
    assign up   = b == 3'(ref_code + 3'd1);
    assign down = b == 3'(ref_code - 3'd1);

    always_comb begin
        state_nx = state;
        ref_nx   = ref_code;
        b_nx     = B;
        step_nx  = 1'b0;
        err_nx   = 1'b0;
        dir_nx   = dir;
        cnt_nx   = err_cnt;
        pos_nx   = pos;
        if (clr) begin
            state_nx = IDLE;
            pos_nx   = '0;
            cnt_nx   = '0;
        end else if (g_valid) begin
            b_nx   = b;
            ref_nx = b;
            case (state)
                IDLE, FAULT: state_nx = TRACK;
                TRACK: begin
                    if (up) begin
                        step_nx = 1'b1;
                        dir_nx  = 1'b1;
                        pos_nx  = pos + POS_W'(1);
                    end else if (down) begin
                        step_nx = 1'b1;
                        dir_nx  = 1'b0;
                        pos_nx  = pos - POS_W'(1);
                    end else if (b != ref_code) begin
                        err_nx   = 1'b1;
                        cnt_nx   = (err_cnt == 4'd15) ? err_cnt : err_cnt + 4'd1;
                        state_nx = FAULT;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ref_code <= '0;
            B        <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            pos      <= '0;
        end else begin
            state    <= state_nx;
            ref_code <= ref_nx;
            B        <= b_nx;
            step     <= step_nx;
            dir      <= dir_nx;
            err      <= err_nx;
            err_cnt  <= cnt_nx;
            pos      <= pos_nx;
        end
    end
endmodule

// File: tb/tb_gray_track_3bit.sv
// tb_gray_track_3bit: scoreboard bench for gray_track_3bit with directed Gray vectors.
module tb_gray_track_3bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] G = 3'd0;
    logic       g_valid = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] B;
    logic       step, dir, err;
    logic [3:0] err_cnt;
    logic [7:0] pos;

    typedef struct {
        string      name;
        logic [2:0] b;
        logic       step;
        logic       dir;
        logic       err;
        logic [3:0] ec;
        logic [7:0] pos;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    gray_track_3bit #(.POS_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .G(G), .g_valid(g_valid), .clr(clr),
        .B(B), .step(step), .dir(dir), .err(err), .err_cnt(err_cnt), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        tests++;
        if (B !== e.b || step !== e.step || dir !== e.dir || err !== e.err ||
            err_cnt !== e.ec || pos !== e.pos) begin
            fails++;
            $display("FAIL %s: got B=%0d step=%0b dir=%0b err=%0b err_cnt=%0d pos=%0d, expected B=%0d step=%0b dir=%0b err=%0b err_cnt=%0d pos=%0d",
                     e.name, B, step, dir, err, err_cnt, pos,
                     e.b, e.step, e.dir, e.err, e.ec, e.pos);
        end
    endtask

    // Monitor: outputs are registered, so each sampled edge is checked on the following negedge.
    always @(negedge clk) if (q.size() > 0) check(q.pop_front());

    task automatic apply(input string name, input logic [2:0] g, input logic v, input logic c,
                         input logic [2:0] eb, input logic es, input logic ed,
                         input logic ee, input logic [3:0] ec, input logic [7:0] ep);
        exp_t e;
        e.name = name; e.b = eb; e.step = es; e.dir = ed; e.err = ee; e.ec = ec; e.pos = ep;
        G = g; g_valid = v; clr = c;
        @(posedge clk);
        q.push_back(e);
        #1;
        g_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [2:0] eb, input logic es,
                             input logic ed, input logic ee, input logic [3:0] ec,
                             input logic [7:0] ep);
        exp_t e;
        e.name = name; e.b = eb; e.step = es; e.dir = ed; e.err = ee; e.ec = ec; e.pos = ep;
        check(e);
    endtask

    initial begin
        logic [2:0] up_g [9];
        logic [2:0] dn_g [9];
        up_g = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        dn_g = '{3'b000, 3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
        #12;
        check_now("reset", 3'd0, 0, 0, 0, 4'd0, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Up sweep: binary 0..7 then wrap to 0.
        apply("up_capture", up_g[0], 1, 0, 3'd0, 0, 0, 0, 4'd0, 8'd0);
        for (int i = 1; i < 9; i++)
            apply("up_step", up_g[i], 1, 0, 3'(i), 1, 1, 0, 4'd0, 8'(i));

        // Down sweep from a cleared position.
        apply("clr_only", 3'b000, 0, 1, 3'd0, 0, 1, 0, 4'd0, 8'd0);
        apply("dn_capture", dn_g[0], 1, 0, 3'd0, 0, 1, 0, 4'd0, 8'd0);
        for (int i = 1; i < 9; i++)
            apply("dn_step", dn_g[i], 1, 0, 3'(8 - i), 1, 0, 0, 4'd0, 8'(256 - i));

        // Position wrap both ways: 0 -> 255 -> 0.
        apply("wrap_clr", 3'b000, 0, 1, 3'd0, 0, 0, 0, 4'd0, 8'd0);
        apply("wrap_capture", 3'b000, 1, 0, 3'd0, 0, 0, 0, 4'd0, 8'd0);
        apply("wrap_down", 3'b100, 1, 0, 3'd7, 1, 0, 0, 4'd0, 8'd255);
        apply("wrap_up", 3'b000, 1, 0, 3'd0, 1, 1, 0, 4'd0, 8'd0);
        apply("valid_low_hold", 3'b011, 0, 0, 3'd0, 0, 1, 0, 4'd0, 8'd0);

        // Illegal jump 0 -> 2, then recapture and a legal move from the new reference.
        apply("jump_capture", 3'b000, 1, 0, 3'd0, 0, 1, 0, 4'd0, 8'd0);
        apply("jump_err", 3'b011, 1, 0, 3'd2, 0, 1, 1, 4'd1, 8'd0);
        apply("fault_recapture", 3'b011, 1, 0, 3'd2, 0, 1, 0, 4'd1, 8'd0);
        apply("track_again", 3'b010, 1, 0, 3'd3, 1, 1, 0, 4'd1, 8'd1);

        // err_cnt saturation over 20 illegal 0 -> 4 jumps.
        apply("sat_clr", 3'b000, 0, 1, 3'd3, 0, 1, 0, 4'd0, 8'd0);
        apply("sat_capture", 3'b000, 1, 0, 3'd0, 0, 1, 0, 4'd0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            apply("sat_err", 3'b110, 1, 0, 3'd4, 0, 1, 1, 4'(i < 15 ? i + 1 : 15), 8'd0);
            apply("sat_recap", 3'b000, 1, 0, 3'd0, 0, 1, 0, 4'(i < 15 ? i + 1 : 15), 8'd0);
        end

        // clr wins over a simultaneous valid at pos=5.
        apply("clr5_clr", 3'b000, 0, 1, 3'd0, 0, 1, 0, 4'd0, 8'd0);
        apply("clr5_capture", up_g[0], 1, 0, 3'd0, 0, 1, 0, 4'd0, 8'd0);
        for (int i = 1; i < 6; i++)
            apply("clr5_step", up_g[i], 1, 0, 3'(i), 1, 1, 0, 4'd0, 8'(i));
        apply("clr_and_valid", 3'b101, 1, 1, 3'd5, 0, 1, 0, 4'd0, 8'd0);
        apply("post_clr_capture", 3'b101, 1, 0, 3'd6, 0, 1, 0, 4'd0, 8'd0);
        apply("post_clr_step", 3'b100, 1, 0, 3'd7, 1, 1, 0, 4'd0, 8'd1);

        // Asynchronous reset mid up-sweep.
        apply("pre_rst_a", 3'b000, 1, 0, 3'd0, 1, 1, 0, 4'd0, 8'd2);
        apply("pre_rst_b", 3'b001, 1, 0, 3'd1, 1, 1, 0, 4'd0, 8'd3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 3'd0, 0, 0, 0, 4'd0, 8'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        apply("post_rst_capture", 3'b010, 1, 0, 3'd3, 0, 0, 0, 4'd0, 8'd0);
        apply("post_rst_step", 3'b110, 1, 0, 3'd4, 1, 1, 0, 4'd0, 8'd1);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
